// File: rtl/heston_pkg.sv
// rtl/heston_pkg.sv - shared Q8.24 constants, accumulator FSM encoding and saturation helper
package heston_pkg;

  localparam int          Q824_FRAC = 24;
  localparam logic [31:0] Q824_ONE  = 32'h0100_0000;
  localparam logic [31:0] Q824_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] Q824_MIN  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acc_state_e;

  // Plain constants so the state register can stay a bare logic vector
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  // Clamp a wide signed value into the 32-bit signed Q8.24 range
  function automatic logic [31:0] sat_q824(input logic signed [63:0] v);
    if (v > 64'sd2147483647) begin
      return Q824_MAX;
    end else if (v < -64'sd2147483648) begin
      return Q824_MIN;
    end else begin
      return v[31:0];
    end
  endfunction

endpackage

// File: rtl/payoff_accumulator_if.sv
// rtl/payoff_accumulator_if.sv - run control, sample and result signals of payoff_accumulator; PAYOFF_SUMSQ_EN adds sumsq_out
interface payoff_accumulator_if;

  logic        start;
  logic [31:0] strike;
  logic        is_put;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s_term;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_out;
  logic [31:0] count_out;
  logic        busy;

`ifdef PAYOFF_SUMSQ_EN
  logic [31:0] sumsq_out;

  modport master (
    output start, strike, is_put, in_valid, s_term, out_ready,
    input  in_ready, out_valid, sum_out, count_out, busy, sumsq_out
  );

  modport slave (
    input  start, strike, is_put, in_valid, s_term, out_ready,
    output in_ready, out_valid, sum_out, count_out, busy, sumsq_out
  );
`else
  modport master (
    output start, strike, is_put, in_valid, s_term, out_ready,
    input  in_ready, out_valid, sum_out, count_out, busy
  );

  modport slave (
    input  start, strike, is_put, in_valid, s_term, out_ready,
    output in_ready, out_valid, sum_out, count_out, busy
  );
`endif

endinterface

// File: rtl/payoff_q824.sv
// rtl/payoff_q824.sv - combinational Q8.24 call/put payoff with positive saturation
module payoff_q824
  import heston_pkg::*;
(
  input  logic [31:0] s_term,
  input  logic [31:0] strike,
  input  logic        is_put,
  output logic [31:0] payoff
);

  logic signed [32:0] s_ext;
  logic signed [32:0] k_ext;
  logic signed [32:0] diff;

  // 33-bit difference cannot wrap; negative clamps to 0, large positive to Q824_MAX
  always_comb begin
    s_ext = {s_term[31], s_term};
    k_ext = {strike[31], strike};
    diff  = is_put ? (k_ext - s_ext) : (s_ext - k_ext);
    if (diff[32]) begin
      payoff = '0;
    end else if (diff[31]) begin
      payoff = Q824_MAX;
    end else begin
      payoff = diff[31:0];
    end
  end

endmodule

// File: rtl/payoff_accumulator.sv
// rtl/payoff_accumulator.sv - accumulates N_PATHS call/put payoffs into a block-scaled sum/count pair; PAYOFF_SUMSQ_EN adds sumsq_out
module payoff_accumulator
  import heston_pkg::*;
#(
  parameter int N_PATHS  = 1024,
  parameter int SCALE_SH = $clog2(N_PATHS),
  parameter int FRAC     = Q824_FRAC
) (
  input logic                 clk,
  input logic                 rst,
  payoff_accumulator_if.slave bus
);

  // One sign bit of headroom over N_PATHS worst-case payoffs, so no overflow check is needed
  localparam int                ACC_W      = 32 + SCALE_SH + 1;
  localparam int                CNT_W      = SCALE_SH + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(N_PATHS - 1);
  localparam logic [63:0]       COUNT_WIDE = (64'(N_PATHS) << FRAC) >> SCALE_SH;
  localparam logic [31:0]       COUNT_VAL  = COUNT_WIDE[31:0];

  logic [1:0]              state_q,     state_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic [31:0]             strike_q,    strike_d;
  logic                    is_put_q,    is_put_d;
  logic                    p1_valid_q,  p1_valid_d;
  logic [31:0]             payoff_q,    payoff_d;
  logic signed [ACC_W-1:0] acc_q,       acc_d;
  logic                    drain_q,     drain_d;
  logic [31:0]             sum_out_q,   sum_out_d;
  logic [31:0]             count_out_q, count_out_d;

  logic [31:0]             payoff_comb;
  logic                    in_fire;
  logic signed [ACC_W-1:0] acc_shifted;

`ifdef PAYOFF_SUMSQ_EN
  localparam int           SQ_TERM_W = 64 - FRAC;
  localparam int           SQ_W      = SQ_TERM_W + SCALE_SH + 1;

  logic [63:0]             sq_full;
  logic [SQ_TERM_W-1:0]    sq_term;
  logic signed [SQ_W-1:0]  sumsq_acc_q, sumsq_acc_d;
  logic signed [SQ_W-1:0]  sumsq_shifted;
  logic [31:0]             sumsq_out_q, sumsq_out_d;
`endif

  payoff_q824 u_payoff (
    .s_term (bus.s_term),
    .strike (strike_q),
    .is_put (is_put_q),
    .payoff (payoff_comb)
  );

  // Next-state: run control, stage 1 (payoff register), stage 2 (accumulate), output formation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    strike_d    = strike_q;
    is_put_d    = is_put_q;
    drain_d     = drain_q;
    sum_out_d   = sum_out_q;
    count_out_d = count_out_q;

    in_fire     = (state_q == ST_ACCUM) && bus.in_valid;
    p1_valid_d  = in_fire;
    payoff_d    = in_fire ? payoff_comb : payoff_q;
    acc_d       = p1_valid_q ? (acc_q + $signed({{(ACC_W-32){1'b0}}, payoff_q})) : acc_q;
    acc_shifted = acc_q >>> SCALE_SH;

`ifdef PAYOFF_SUMSQ_EN
    sq_full       = 64'(payoff_q) * 64'(payoff_q);
    sq_term       = SQ_TERM_W'(sq_full >> FRAC);
    sumsq_acc_d   = p1_valid_q ? (sumsq_acc_q + $signed({{(SQ_W-SQ_TERM_W){1'b0}}, sq_term}))
                               : sumsq_acc_q;
    sumsq_shifted = sumsq_acc_q >>> SCALE_SH;
    sumsq_out_d   = sumsq_out_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_ACCUM;
          cnt_d    = '0;
          acc_d    = '0;
          strike_d = bus.strike;
          is_put_d = bus.is_put;
`ifdef PAYOFF_SUMSQ_EN
          sumsq_acc_d = '0;
`endif
        end
      end
      ST_ACCUM: begin
        if (in_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        // First cycle flushes the payoff stage, second the accumulate stage
        drain_d = 1'b1;
        if (drain_q) begin
          state_d     = ST_DONE;
          sum_out_d   = sat_q824({{(64-ACC_W){acc_shifted[ACC_W-1]}}, acc_shifted});
          count_out_d = COUNT_VAL;
`ifdef PAYOFF_SUMSQ_EN
          sumsq_out_d = sat_q824({{(64-SQ_W){sumsq_shifted[SQ_W-1]}}, sumsq_shifted});
`endif
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any run in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      strike_q    <= '0;
      is_put_q    <= 1'b0;
      p1_valid_q  <= 1'b0;
      payoff_q    <= '0;
      acc_q       <= '0;
      drain_q     <= 1'b0;
      sum_out_q   <= '0;
      count_out_q <= '0;
`ifdef PAYOFF_SUMSQ_EN
      sumsq_acc_q <= '0;
      sumsq_out_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      strike_q    <= strike_d;
      is_put_q    <= is_put_d;
      p1_valid_q  <= p1_valid_d;
      payoff_q    <= payoff_d;
      acc_q       <= acc_d;
      drain_q     <= drain_d;
      sum_out_q   <= sum_out_d;
      count_out_q <= count_out_d;
`ifdef PAYOFF_SUMSQ_EN
      sumsq_acc_q <= sumsq_acc_d;
      sumsq_out_q <= sumsq_out_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum_out   = sum_out_q;
  assign bus.count_out = count_out_q;
`ifdef PAYOFF_SUMSQ_EN
  assign bus.sumsq_out = sumsq_out_q;
`endif

endmodule

// File: doc/payoff_accumulator.md
Name: payoff_accumulator

Overview:
- Upstream producer of the (sum, count) pair consumed by discount_engine.
- Accepts terminal asset prices S_T (Q8.24) from the Heston path simulators over a valid/ready handshake.
- Computes the call or put payoff against a latched strike and accumulates N_PATHS payoffs.
- Presents a block-scaled sum_out/count_out pair whose quotient is the mean payoff in Q8.24. out_valid drives discount_engine's en.

Parameters:
- N_PATHS, 1024, number of paths per pricing run (power of two, 2..65536).
- SCALE_SH, $clog2(N_PATHS), common right-shift applied to both sum and count.
- FRAC, 24, fractional bits of the fixed-point format.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- strike  in  32  K, Q8.24 signed; latched on accepted start
- is_put  in  1  0=call, 1=put; latched on accepted start
- in_valid  in  1  s_term valid
- in_ready  out  1  block can accept s_term
- s_term  in  32  terminal price S_T, Q8.24 signed
- out_valid  out  1  sum_out/count_out valid
- out_ready  in  1  consumer accepts result
- sum_out  out  32  accumulated payoff >>> SCALE_SH, Q8.24 signed, saturated
- count_out  out  32  (paths << FRAC) >>> SCALE_SH, Q8.24 signed
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: in_ready=0, out_valid=0, sum_out=0, count_out=0, busy=0, FSM=IDLE. Internal accumulator, path counter and pipeline registers are cleared. Reset mid-run abandons the run with no output.
- States:
  - IDLE: start=1 → ACCUM. Clears the accumulator and counter and latches strike and is_put.
  - ACCUM: in_ready=1. A sample is accepted when in_valid&&in_ready. When the N_PATHS-th sample is accepted, in_ready drops the next cycle → DRAIN.
  - DRAIN: 2 cycles to flush the payoff and accumulate stages → DONE.
  - DONE: out_valid=1, outputs stable. When out_valid&&out_ready → IDLE and out_valid drops the next cycle.
- start is ignored outside IDLE.
- in_valid is ignored outside ACCUM. Backpressure is only via in_ready; no samples are lost or double-counted.
- Pipeline:
  - Stage 1 registers payoff. Call = max(S_T−K, 0); put = max(K−S_T, 0). The subtraction is 33-bit and the positive result is saturated to 0x7FFF_FFFF.
  - Stage 2 adds the payoff into a (32+SCALE_SH+1)-bit signed accumulator, which cannot overflow.
  - Latency from last accepted sample to out_valid: 3 cycles.
- Output formation at DRAIN exit:
  - sum_out = acc >>> SCALE_SH, saturated to the 32-bit signed range.
  - count_out = (N_PATHS << FRAC) >>> SCALE_SH (0x0100_0000 for the default).
- Path counter is (SCALE_SH+1) bits and wraps only via IDLE clear.
- in_valid gaps of any length are allowed.
- out_ready held high in DONE gives a 1-cycle out_valid pulse.

Optional Feature:
- Macro PAYOFF_SUMSQ_EN.
- Defined: adds output port sumsq_out (32, Q8.24), reset 0, valid with out_valid.
  - Stage 2 also accumulates (payoff*payoff)>>>FRAC into a second wide accumulator.
  - sumsq_out = sumsq_acc >>> SCALE_SH, saturated. Used for the standard-error estimate.
- Undefined: no port, no second multiplier or accumulator; all other behaviour is identical.

Decomposition:
- Shared package (heston_pkg):
  - Q824_FRAC=24
  - Q824_ONE=32'h0100_0000
  - Q824_MAX/Q824_MIN saturation constants
  - FSM state enum {IDLE, ACCUM, DRAIN, DONE}
- One sub-module: payoff_q824, the combinational call/put payoff with saturation, registered by the parent.

Test Plan:
- N_PATHS=4; K=0x0100_0000, call; S_T=1.5, 0.5, 2.0, 1.0 (0x0180_0000, 0x0080_0000, 0x0200_0000, 0x0100_0000) → sum_out=0x0060_0000 (0.375), count_out=0x0100_0000, out_valid 3 cycles after the 4th accept.
- Same stimulus with is_put=1 → sum_out=0x0020_0000 (0.125); payoff for S_T=K is exactly 0.
- in_valid toggled 1-0-1-0 and out_ready held low 10 cycles in DONE → results unchanged, out_valid stays high, no extra samples are accepted, in_ready=0 after the 4th accept.
- S_T=0x7FFF_FFFF, K=0x8000_0000 (call) → payoff saturates to 0x7FFF_FFFF; the four-sample sum_out equals 0x7FFF_FFFF, with no wrap.
- rst asserted after 2 accepts, then a new start with a fresh 4 samples → outputs reflect only the new run; start pulsed during ACCUM is ignored.
- With PAYOFF_SUMSQ_EN, the first stimulus → sumsq_out=0x0050_0000 ((0.25+1.0)/4=0.3125).
